// File: rtl/uart_tx_if.sv
// Parallel request/config side and serial line of the UART transmitter.
// The master is the byte source; the slave is uart_tx.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] TX_P_Data;
  logic                  TX_Data_Valid;
  logic                  TX_Parity_Enable;
  logic                  TX_Parity_Type;
  logic [3:0]            TX_Prescale;
  logic                  TX_OUT;
  logic                  TX_Busy;

  modport master (
    output TX_P_Data, TX_Data_Valid, TX_Parity_Enable, TX_Parity_Type, TX_Prescale,
    input  TX_OUT, TX_Busy
  );

  modport slave (
    input  TX_P_Data, TX_Data_Valid, TX_Parity_Enable, TX_Parity_Type, TX_Prescale,
    output TX_OUT, TX_Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit,
// each bit held for a latched prescale P (clamped to >= 4) clock cycles.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic   CLK,
  input  logic   RST,
  uart_tx_if.slave bus
);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic [3:0]            presc_q;
  logic [3:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  tx_out;
  logic                  busy;

  logic [3:0]    presc_clamp;
  logic          bit_end;
  logic          par_bit;
  logic [BW-1:0] bit_next;

  assign presc_clamp = (bus.TX_Prescale < 4'd4) ? 4'd4 : bus.TX_Prescale;
  assign bit_end     = (edge_cnt == presc_q - 4'd1);
  assign par_bit     = par_type_q ? ~^data_q : ^data_q;
  assign bit_next    = bit_cnt + BW'(1);

  assign bus.TX_OUT  = tx_out;
  assign bus.TX_Busy = busy;

  // tx_out is loaded with the value of the bit being entered, so the line
  // changes on the same edge the state does.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      presc_q    <= 4'd4;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (bus.TX_Data_Valid) begin
            data_q     <= bus.TX_P_Data;
            par_en_q   <= bus.TX_Parity_Enable;
            par_type_q <= bus.TX_Parity_Type;
            presc_q    <= presc_clamp;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        default: begin
          if (!bit_end) begin
            edge_cnt <= edge_cnt + 4'd1;
          end else begin
            edge_cnt <= '0;
            case (state)
              START: begin
                bit_cnt <= '0;
                tx_out  <= data_q[0];
                state   <= DATA;
              end
              DATA: begin
                if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                  bit_cnt <= '0;
                  if (par_en_q) begin
                    tx_out <= par_bit;
                    state  <= PARITY;
                  end else begin
                    tx_out <= 1'b1;
                    state  <= STOP;
                  end
                end else begin
                  bit_cnt <= bit_next;
                  tx_out  <= data_q[bit_next];
                end
              end
              PARITY: begin
                tx_out <= 1'b1;
                state  <= STOP;
              end
              default: begin
                tx_out <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model checked every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_uart_tx;
  logic CLK;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  uart_tx_if #(.DATA_WIDTH(8)) bus();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Frame-level model: on accept, build the whole frame as a bit list; the
  // expected line value is the frame bit indexed by elapsed cycles / P.
  bit m_active;
  int m_t;
  int m_n;
  int m_p;
  bit m_bits[11];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t >= m_n * m_p) m_active = 1'b0;
    end else if (bus.TX_Data_Valid) begin
      int ones;
      ones = 0;
      m_p = (bus.TX_Prescale < 4) ? 4 : int'(bus.TX_Prescale);
      m_n = bus.TX_Parity_Enable ? 11 : 10;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_bits[i+1] = bus.TX_P_Data[i];
        ones += int'(bus.TX_P_Data[i]);
      end
      if (bus.TX_Parity_Enable)
        m_bits[9] = bus.TX_Parity_Type ? ((ones % 2) == 0) : ((ones % 2) == 1);
      m_bits[m_n-1] = 1'b1;
      m_t = 0;
      m_active = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic exp_out;
      logic exp_busy;
      exp_out  = m_active ? m_bits[m_t / m_p] : 1'b1;
      exp_busy = m_active;
      n_checks++;
      if (bus.TX_OUT !== exp_out || bus.TX_Busy !== exp_busy) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d out=%b busy=%b required out=%b busy=%b",
                 cyc, bus.TX_OUT, bus.TX_Busy, exp_out, exp_busy);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout at cyc=%0d actual=no_event required=event", name, cyc);
  endtask

  // One-cycle request pulse; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [3:0] ps);
    bus.TX_P_Data        = d;
    bus.TX_Parity_Enable = pe;
    bus.TX_Parity_Type   = pt;
    bus.TX_Prescale      = ps;
    bus.TX_Data_Valid    = 1'b1;
    @(negedge CLK);
    bus.TX_Data_Valid    = 1'b0;
  endtask

  // Records the line while busy; frame bit i is taken mid-bit at sample i*P+P/2.
  task automatic capture(input int p, output logic [10:0] bits, output int busy_cnt);
    logic samples[$];
    bit   done;
    bits     = '0;
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (bus.TX_Busy) begin
        samples.push_back(bus.TX_OUT);
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        done = 1'b1;
      end
      if (!done) @(negedge CLK);
    end
    if (!done) timeout("capture");
    for (int i = 0; i < 11; i++)
      if (i * p + p / 2 < samples.size()) bits[i] = samples[i*p + p/2];
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    while (bus.TX_Busy !== lvl && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (bus.TX_Busy !== lvl) timeout(name);
  endtask

  logic [10:0] bits;
  int          bcnt;
  int          t1;
  int          t2;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    RST      = 1'b0;
    bus.TX_P_Data = '0;
    bus.TX_Data_Valid = 1'b0;
    bus.TX_Parity_Enable = 1'b0;
    bus.TX_Parity_Type = 1'b0;
    bus.TX_Prescale = 4'd8;
    repeat (3) @(negedge CLK);
    check("reset_out", int'(bus.TX_OUT), 1);
    check("reset_busy", int'(bus.TX_Busy), 0);
    RST = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);

    // 0xA5, no parity, P=8
    send(8'hA5, 1'b0, 1'b0, 4'd8);
    check("first_bit_start", int'(bus.TX_OUT), 0);
    capture(8, bits, bcnt);
    check("a5_frame", int'(bits[9:0]), 'h34A);
    check("a5_busy", bcnt, 80);

    // Parity cases
    send(8'h07, 1'b1, 1'b0, 4'd8);
    capture(8, bits, bcnt);
    check("p07_even_bit", int'(bits[9]), 1);
    check("p07_even_busy", bcnt, 88);
    check("p07_stop", int'(bits[10]), 1);
    send(8'h07, 1'b1, 1'b1, 4'd8);
    capture(8, bits, bcnt);
    check("p07_odd_bit", int'(bits[9]), 0);
    check("p07_odd_busy", bcnt, 88);
    send(8'h00, 1'b1, 1'b0, 4'd8);
    capture(8, bits, bcnt);
    check("p00_even_bit", int'(bits[9]), 0);
    check("p00_even_busy", bcnt, 88);

    // Request while busy is dropped
    send(8'h3C, 1'b0, 1'b0, 4'd8);
    fork
      capture(8, bits, bcnt);
      begin
        repeat (19) @(negedge CLK);
        bus.TX_P_Data = 8'hFF;
        bus.TX_Data_Valid = 1'b1;
        @(negedge CLK);
        bus.TX_Data_Valid = 1'b0;
      end
    join
    check("busy_drop_data", int'(bits[8:1]), 'h3C);
    check("busy_drop_len", bcnt, 80);
    repeat (20) @(negedge CLK);
    check("busy_drop_idle", int'(bus.TX_Busy), 0);

    // Held request: second start exactly N*P+1 cycles after the first
    bus.TX_P_Data = 8'h55;
    bus.TX_Parity_Enable = 1'b0;
    bus.TX_Prescale = 4'd8;
    bus.TX_Data_Valid = 1'b1;
    @(negedge CLK);
    t1 = cyc;
    wait_busy(1'b0, "held_fall");
    wait_busy(1'b1, "held_rise");
    t2 = cyc;
    bus.TX_Data_Valid = 1'b0;
    check("b2b_gap", t2 - t1, 81);
    wait_busy(1'b0, "held_done");
    @(negedge CLK);

    // Prescale boundaries
    send(8'h81, 1'b0, 1'b0, 4'd4);
    capture(4, bits, bcnt);
    check("p4_data", int'(bits[8:1]), 'h81);
    check("p4_busy", bcnt, 40);
    send(8'h5A, 1'b0, 1'b0, 4'd15);
    capture(15, bits, bcnt);
    check("p15_data", int'(bits[8:1]), 'h5A);
    check("p15_busy", bcnt, 150);
    send(8'hC3, 1'b0, 1'b0, 4'd2);
    capture(4, bits, bcnt);
    check("p2_data", int'(bits[8:1]), 'hC3);
    check("p2_busy", bcnt, 40);
    send(8'h96, 1'b1, 1'b1, 4'd8);
    fork
      capture(8, bits, bcnt);
      begin
        repeat (10) @(negedge CLK);
        bus.TX_Prescale = 4'd4;
      end
    join
    check("presc_chg_data", int'(bits[8:1]), 'h96);
    check("presc_chg_busy", bcnt, 88);

    // Random bytes, parity on/off, decoded from the line
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      send(d, pe, pt, 4'd8);
      capture(8, bits, bcnt);
      check("rand_data", int'(bits[8:1]), int'(d));
      check("rand_busy", bcnt, pe ? 88 : 80);
    end

    // Asynchronous reset mid-DATA
    send(8'hA5, 1'b0, 1'b0, 4'd8);
    repeat (20) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("async_rst_out", int'(bus.TX_OUT), 1);
    check("async_rst_busy", int'(bus.TX_Busy), 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (100) @(negedge CLK);
    check("post_rst_out", int'(bus.TX_OUT), 1);
    check("post_rst_busy", int'(bus.TX_Busy), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
